// File: rtl/sensor_pattern_gen.sv
// sensor_pattern_gen: synthesizable sensor timing and pixel source.
// Produces BPF/HACT/VACT framing with ramp, LFSR, constant or checker data.
// Frames are free-running (video=1) or started by a trigger. A trigger that
// arrives during a frame waits in a one-deep queue. A further trigger while
// the queue is full is dropped and reported on trig_miss.
module sensor_pattern_gen #(
  parameter int DW      = 12,
  parameter int LLINE   = 192,
  parameter int NCOLS   = 66,
  parameter int NROWS   = 18,
  parameter int NROWB   = 1,
  parameter int NROWA   = 1,
  parameter int NBPF    = 20,
  parameter int NGP1    = 8,
  parameter int NVLO    = 1,
  parameter int TRIGDLY = 8
) (
  input  logic          MCLK,
  input  logic          MRST,
  input  logic          en,
  input  logic          video,
  input  logic          trig,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] const_val,
  output logic [DW-1:0] D,
  output logic          BPF,
  output logic          HACT,
  output logic          VACT,
  output logic          VACT1,
  output logic [15:0]   frame_num,
  output logic          trig_miss,
  output logic          busy
);

  // The VSTART clock is the first clock of the pre-blank period. The
  // pre-blank period is therefore never shorter than that one clock.
  localparam logic [31:0] PRE_LEN   = (NROWB * LLINE > 0) ? 32'(NROWB * LLINE) : 32'd1;
  localparam logic [31:0] POST_LEN  = 32'(NROWA * LLINE);
  localparam logic [31:0] TDLY_LEN  = (TRIGDLY * LLINE > 0) ? 32'(TRIGDLY * LLINE) : 32'd1;
  localparam logic [31:0] LINE_LAST = 32'(LLINE - 1);
  localparam logic [31:0] VLO_LAST  = 32'(NVLO - 1);
  localparam logic [31:0] HSTART    = 32'(NBPF + NGP1);
  localparam logic [31:0] NCOLS_U   = 32'(NCOLS);
  localparam logic [11:0] ROW_LAST  = 12'(NROWS - 1);

  generate
    if (LLINE < NBPF + NGP1 + NCOLS + 1) begin : g_bad_line
      $error("sensor_pattern_gen: LLINE must be >= NBPF+NGP1+NCOLS+1");
    end
    if (NVLO < 1) begin : g_bad_vlo
      $error("sensor_pattern_gen: NVLO must be >= 1");
    end
    if (NROWS < 1) begin : g_bad_rows
      $error("sensor_pattern_gen: NROWS must be >= 1");
    end
    if (DW < 1 || DW > 16) begin : g_bad_dw
      $error("sensor_pattern_gen: DW must be 1..16");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_TDLY, S_VSTART, S_PRE, S_LINE, S_POST, S_VLO
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [31:0]   t_q, t_d;
  logic [11:0]   row_q, row_d;
  logic          pending_q, pending_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [15:0]   frame_q, frame_d;
  logic [DW-1:0] d_q, d_d;
  logic          bpf_q, bpf_d;
  logic          hact_q, hact_d;
  logic          vact_q, vact_d;
  logic          vact1_q, vact1_d;
  logic          miss_q, miss_d;
  logic          busy_q, busy_d;

  logic          trig_ev;
  logic          bpf_win;
  logic [31:0]   hrel;
  logic [11:0]   col;
  logic          pix;

  // Sequencer: next state, phase timers, line/row counters and the trigger queue.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 32'd1;
    t_d       = t_q;
    row_d     = row_q;
    pending_d = pending_q;
    miss_d    = 1'b0;
    frame_d   = frame_q;
    trig_ev   = trig & ~video;

    if (state_q != S_IDLE && trig_ev) begin
      if (pending_q) miss_d = 1'b1;
      else           pending_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = 32'd0;
        if (en && video)        state_d = S_VSTART;
        else if (en && trig_ev) state_d = S_TDLY;
      end
      S_TDLY: begin
        if (cnt_q == TDLY_LEN - 32'd1) state_d = S_VSTART;
      end
      S_VSTART: begin
        t_d   = 32'd0;
        row_d = 12'd0;
        state_d = (PRE_LEN == 32'd1) ? S_LINE : S_PRE;
      end
      S_PRE: begin
        if (cnt_q == PRE_LEN - 32'd1) begin
          state_d = S_LINE;
          t_d     = 32'd0;
          row_d   = 12'd0;
        end
      end
      S_LINE: begin
        t_d = t_q + 32'd1;
        if (t_q == LINE_LAST) begin
          t_d   = 32'd0;
          row_d = row_q + 12'd1;
          if (row_q == ROW_LAST) begin
            cnt_d   = 32'd0;
            state_d = (POST_LEN == 32'd0) ? S_VLO : S_POST;
          end
        end
      end
      S_POST: begin
        if (cnt_q == POST_LEN - 32'd1) begin
          state_d = S_VLO;
          cnt_d   = 32'd0;
        end
      end
      S_VLO: begin
        if (cnt_q == VLO_LAST) begin
          if (en && video) begin
            state_d = S_VSTART;
          end else if (en && pending_q) begin
            // The queued trigger starts the delay, and a trigger arriving
            // in this same clock takes its place in the queue.
            state_d   = S_TDLY;
            pending_d = trig_ev;
            miss_d    = 1'b0;
          end else if (en && trig_ev) begin
            state_d   = S_TDLY;
            pending_d = 1'b0;
          end else begin
            state_d   = S_IDLE;
            pending_d = 1'b0;
            miss_d    = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_VSTART) begin
      frame_d = frame_q + 16'd1;
      cnt_d   = 32'd0;
    end
    if (state_d == S_TDLY && state_q != S_TDLY) cnt_d = 32'd0;
  end

  generate
    if (NBPF > 0) begin : g_bpf
      assign bpf_win = (t_d < 32'(NBPF));
    end else begin : g_no_bpf
      assign bpf_win = 1'b0;
    end
  endgenerate

  // Output decode from the next state so every output register lines up with its state.
  always_comb begin
    vact_d  = (state_d == S_VSTART) || (state_d == S_PRE) ||
              (state_d == S_LINE)   || (state_d == S_POST);
    vact1_d = (state_d == S_VSTART);
    busy_d  = (state_d != S_IDLE);
    // Wraps to a huge value before HACT start, so one compare bounds the window.
    hrel    = t_d - HSTART;
    hact_d  = (state_d == S_LINE) && (hrel < NCOLS_U);
    bpf_d   = (state_d == S_LINE) && bpf_win;
    col     = bpf_d ? t_d[11:0] : hrel[11:0];
    pix     = bpf_d | hact_d;
    lfsr_d  = lfsr_q;
    d_d     = '0;
    if (pix) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      case (mode)
        2'd0:    d_d = DW'({row_d, 8'h00} + {8'h00, col});
        2'd1:    d_d = lfsr_q[DW-1:0];
        2'd2:    d_d = const_val;
        default: d_d = {DW{row_d[0] ^ col[0]}};
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge MCLK) begin
    if (MRST) begin
      state_q   <= S_IDLE;
      cnt_q     <= 32'd0;
      t_q       <= 32'd0;
      row_q     <= 12'd0;
      pending_q <= 1'b0;
      lfsr_q    <= 16'hACE1;
      frame_q   <= 16'd0;
      d_q       <= '0;
      bpf_q     <= 1'b0;
      hact_q    <= 1'b0;
      vact_q    <= 1'b0;
      vact1_q   <= 1'b0;
      miss_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      t_q       <= t_d;
      row_q     <= row_d;
      pending_q <= pending_d;
      lfsr_q    <= lfsr_d;
      frame_q   <= frame_d;
      d_q       <= d_d;
      bpf_q     <= bpf_d;
      hact_q    <= hact_d;
      vact_q    <= vact_d;
      vact1_q   <= vact1_d;
      miss_q    <= miss_d;
      busy_q    <= busy_d;
    end
  end

  assign D         = d_q;
  assign BPF       = bpf_q;
  assign HACT      = hact_q;
  assign VACT      = vact_q;
  assign VACT1     = vact1_q;
  assign frame_num = frame_q;
  assign trig_miss = miss_q;
  assign busy      = busy_q;

endmodule
